// File: rtl/nios_system_pio_pkg.sv
// Shared register offsets and status bit positions for the Nios output PIO.
package nios_system_pio_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_STATUS    = 3'd1;
    localparam logic [2:0] ADDR_OUTSET    = 3'd2;
    localparam logic [2:0] ADDR_OUTCLEAR  = 3'd3;
    localparam logic [2:0] ADDR_ACK_COUNT = 3'd4;

    localparam int STAT_PENDING = 0;
    localparam int STAT_OVERRUN = 1;

endpackage

// File: rtl/nios_system_pio_update_tracker.sv
// Tracks whether an update is pending for the consumer, a sticky overrun
// flag, and how many updates the consumer has accepted.
module nios_system_pio_update_tracker #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   update,
    input  logic                   xfer_ack,
    input  logic                   clr_overrun,
    input  logic                   clr_count,
    output logic                   pending,
    output logic                   overrun,
    output logic [COUNT_WIDTH-1:0] ack_count
);

    logic xfer;

    assign xfer = pending && xfer_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= 1'b0;
            overrun   <= 1'b0;
            ack_count <= '0;
        end else begin
            // A new update keeps pending set even when the old value is taken now.
            if (update)
                pending <= 1'b1;
            else if (xfer)
                pending <= 1'b0;

            if (update && pending && !xfer)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;

            if (clr_count)
                ack_count <= '0;
            else if (xfer)
                ack_count <= ack_count + 1'b1;
        end
    end

endmodule

// File: rtl/nios_system_alien_x_position_out.sv
// Avalon-MM output PIO for the alien X position with set/clear registers,
// a valid/ack handshake toward the consumer and a registered read path.
module nios_system_alien_x_position_out
    import nios_system_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 3,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter int                    COUNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  out_valid,
    input  logic                  out_ack
);

    logic                   wr;
    logic                   update;
    logic                   clr_overrun;
    logic                   clr_count;
    logic                   pending;
    logic                   overrun;
    logic [COUNT_WIDTH-1:0] ack_count;
    logic [DATA_WIDTH-1:0]  data;
    logic [DATA_WIDTH-1:0]  wr_bits;
    logic [31:0]            rd_mux;
    logic                   unused_wdata;

    assign wr           = chipselect && !write_n;
    assign wr_bits      = writedata[DATA_WIDTH-1:0];
    assign unused_wdata = ^(writedata >> DATA_WIDTH);

    assign update      = wr && (address == ADDR_DATA || address == ADDR_OUTSET ||
                                address == ADDR_OUTCLEAR);
    assign clr_overrun = wr && (address == ADDR_STATUS) && writedata[STAT_OVERRUN];
    assign clr_count   = wr && (address == ADDR_ACK_COUNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= RESET_VALUE;
        end else if (wr) begin
            case (address)
                ADDR_DATA:     data <= wr_bits;
                ADDR_OUTSET:   data <= data | wr_bits;
                ADDR_OUTCLEAR: data <= data & ~wr_bits;
                default:       data <= data;
            endcase
        end
    end

    nios_system_pio_update_tracker #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_tracker (
        .clk         (clk),
        .reset_n     (reset_n),
        .update      (update),
        .xfer_ack    (out_ack),
        .clr_overrun (clr_overrun),
        .clr_count   (clr_count),
        .pending     (pending),
        .overrun     (overrun),
        .ack_count   (ack_count)
    );

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux = 32'(data);
            ADDR_STATUS: begin
                rd_mux[STAT_PENDING] = pending;
                rd_mux[STAT_OVERRUN] = overrun;
            end
            ADDR_ACK_COUNT: rd_mux = 32'(ack_count);
            default: rd_mux = '0;
        endcase
    end

    // No read strobe: the mux is captured every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= rd_mux;
    end

    assign out_port  = data;
    assign out_valid = pending;

endmodule
